// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: state encoding, line idle level and parity.
// The matching receiver imports this same package.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam int   MAX_DATA_W = 16;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit period timer: tick is high on the last clock of each CLKS_PER_BIT-long bit.
// Holding clear restarts the period so every state entry begins a fresh bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            TW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Each line bit is held for CLKS_PER_BIT clocks; a word is accepted only while idle.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int            IW       = $clog2(DATA_W) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              done_q, done_d;
    logic              tick;
    logic              accept;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign busy       = (state_q != IDLE);
    assign load_ready = ~busy;
    assign done       = done_q;
    // Reset takes priority over a simultaneous offer.
    assign accept     = load_valid & load_ready & ~reset;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        done_d  = 1'b0;
        tx_out  = LINE_IDLE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shreg_d = data_in;
                    word_d  = data_in;
                end
            end
            START: begin
                tx_out = 1'b0;
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                tx_out = shreg_q[0];
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                tx_out = even_parity(MAX_DATA_W'(word_q));
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_out = LINE_IDLE;
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Payload registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        word_q  <= word_d;
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three instances cover parity on, parity off and one clock per bit.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din [3];
    logic [2:0] lv;
    logic [2:0] lr;
    logic [2:0] tx;
    logic [2:0] bsy;
    logic [2:0] dn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_par (
        .clk(clk), .reset(reset), .data_in(din[0]), .load_valid(lv[0]),
        .load_ready(lr[0]), .tx_out(tx[0]), .busy(bsy[0]), .done(dn[0]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_nopar (
        .clk(clk), .reset(reset), .data_in(din[1]), .load_valid(lv[1]),
        .load_ready(lr[1]), .tx_out(tx[1]), .busy(bsy[1]), .done(dn[1]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_fast (
        .clk(clk), .reset(reset), .data_in(din[2]), .load_valid(lv[2]),
        .load_ready(lr[2]), .tx_out(tx[2]), .busy(bsy[2]), .done(dn[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the accept cycle; returns in the done cycle.
    // seq bit b is the b-th line bit of the frame (bit 0 = start bit).
    task automatic frame(input int s, input logic [7:0] w, input logic [10:0] seq,
                         input int nbits, input int cpb, input bit disturb, input string tag);
        din[s] = w;
        lv[s]  = 1'b1;
        check({tag, " ready_at_accept"}, 32'(lr[s]), 32'd1);
        step();
        lv[s] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < cpb; k++) begin
                check($sformatf("%s tx b%0d c%0d", tag, b, k), 32'(tx[s]), 32'(seq[b]));
                check($sformatf("%s busy b%0d c%0d", tag, b, k), 32'(bsy[s]), 32'd1);
                check($sformatf("%s done b%0d c%0d", tag, b, k), 32'(dn[s]), 32'd0);
                check($sformatf("%s ready b%0d c%0d", tag, b, k), 32'(lr[s]), 32'd0);
                if (disturb && b == 3 && k == 0) begin
                    lv[s]  = 1'b1;
                    din[s] = ~w;
                end
                if (disturb && b == 3 && k == 2) begin
                    lv[s] = 1'b0;
                end
                step();
            end
        end
        check({tag, " done_pulse"}, 32'(dn[s]), 32'd1);
        check({tag, " busy_after"}, 32'(bsy[s]), 32'd0);
        check({tag, " ready_in_done"}, 32'(lr[s]), 32'd1);
        check({tag, " tx_idle_done"}, 32'(tx[s]), 32'd1);
    endtask

    task automatic idle_after(input int s, input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            step();
            check($sformatf("%s done_low %0d", tag, i), 32'(dn[s]), 32'd0);
            check($sformatf("%s tx_high %0d", tag, i), 32'(tx[s]), 32'd1);
            check($sformatf("%s busy_low %0d", tag, i), 32'(bsy[s]), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        lv    = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;

        // Reset held three cycles, with an offer present that must be ignored.
        lv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst tx %0d", i), 32'(tx), 32'b111);
            check($sformatf("rst ready %0d", i), 32'(lr), 32'b111);
            check($sformatf("rst busy %0d", i), 32'(bsy), 32'b000);
            check($sformatf("rst done %0d", i), 32'(dn), 32'b000);
        end
        lv[0] = 1'b0;
        reset = 1'b0;
        step();
        check("post_rst tx", 32'(tx), 32'b111);
        check("post_rst ready", 32'(lr), 32'b111);
        check("post_rst busy", 32'(bsy), 32'b000);

        // A5: bits 1,0,1,0,0,1,0,1, parity 0
        frame(0, 8'hA5, 11'b1_0_10100101_0, 11, 4, 1'b0, "A5");
        idle_after(0, 2, "A5");

        // 07: three ones, parity 1
        frame(0, 8'h07, 11'b1_1_00000111_0, 11, 4, 1'b0, "07");
        idle_after(0, 1, "07");

        // 07 without parity: 40-cycle frame, done at cycle 41
        frame(1, 8'h07, 11'b0_1_00000111_0, 10, 4, 1'b0, "07np");
        idle_after(1, 1, "07np");

        // FF with data_in/load_valid disturbance while busy, then 00 accepted in the done cycle
        frame(0, 8'hFF, 11'b1_0_11111111_0, 11, 4, 1'b1, "FF");
        frame(0, 8'h00, 11'b1_0_00000000_0, 11, 4, 1'b0, "00b2b");
        idle_after(0, 3, "00b2b");

        // Reset in cycle 20 of an A5 frame
        din[0] = 8'hA5;
        lv[0]  = 1'b1;
        step();
        lv[0] = 1'b0;
        for (int c = 1; c < 20; c++) step();
        check("abort pre tx", 32'(tx[0]), 32'd0);
        check("abort pre busy", 32'(bsy[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort tx", 32'(tx[0]), 32'd1);
        check("abort busy", 32'(bsy[0]), 32'd0);
        check("abort done", 32'(dn[0]), 32'd0);
        idle_after(0, 30, "abort");
        frame(0, 8'h3C, 11'b1_0_00111100_0, 11, 4, 1'b0, "3C");
        idle_after(0, 1, "3C");

        // One clock per bit: 81 -> 0,1,0,0,0,0,0,0,1,0,1
        frame(2, 8'h81, 11'b1_0_10000001_0, 11, 1, 1'b0, "81fast");
        idle_after(2, 2, "81fast");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
